ex_mem_pipe_irq: RTL

- Execute→Memory pipeline register for the 8-bit processor; feeds the memory-stage control decoder and the data-memory port.
- Also owns the interrupt-entry sequencer that produces the registered interrupt flag sf1.
- On an interrupt it drains the execute slot, then injects one PC-push memory slot (write of the return PC to the stack address).
- It then pulses an acknowledge so fetch can load the vector.

---
 rtl/ex_mem_pipe_irq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_irq.sv
// rtl/ex_mem_pipe_irq.sv - EX->MEM pipeline register with interrupt-entry sequencer
//
// Purpose:
//   Registers the execute-stage slot into the memory stage. When an interrupt
//   request arrives, it lets the in-flight EX instruction finish, injects one
//   PC-push memory slot (return PC written to the stack address), then pulses
//   irq_ack so fetch can load the vector.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 hold every register and sequencer state
//   flush                 replace the captured EX slot with a bubble
//   ex_valid, ex_ir       EX slot valid flag and instruction
//   ex_alu_res            ALU result from EX
//   ex_mem_addr           effective memory address from EX
//   ex_wdata              store data from EX
//   irq                   level interrupt request
//   irq_pc                return PC from fetch
//   sp_in                 current stack pointer
//   mem_valid, mem_ir     registered MEM slot valid flag and instruction
//   mem_alu_res           registered ALU result
//   mem_addr, mem_wdata   registered data-memory address and write data
//   sf1                   registered interrupt flag, high with the push slot
//   irq_busy              upstream must stop issuing while high
//   irq_ack               one-cycle pulse after the push slot

module ex_mem_pipe_irq #(
   parameter int               DATA_W = 8,
   parameter logic [DATA_W-1:0] NOP_IR = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_ir,
   input  logic [DATA_W-1:0] ex_alu_res,
   input  logic [DATA_W-1:0] ex_mem_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              irq,
   input  logic [DATA_W-1:0] irq_pc,
   input  logic [DATA_W-1:0] sp_in,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_ir,
   output logic [DATA_W-1:0] mem_alu_res,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              sf1,
   output logic              irq_busy,
   output logic              irq_ack
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] PUSH = 2'd2;
   localparam logic [1:0] ACK  = 2'd3;

   logic [1:0] state;
   // Cleared on entry; re-set only after irq is seen low in IDLE, so a
   // request held high produces exactly one entry.
   logic       armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         armed       <= 1'b1;
         mem_valid   <= 1'b0;
         mem_ir      <= NOP_IR;
         mem_alu_res <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         sf1         <= 1'b0;
         irq_busy    <= 1'b0;
         irq_ack     <= 1'b0;
      end else if (!stall) begin
         case (state)
            PUSH: begin
               // Injected slot wins over flush: stack write of the return PC.
               mem_valid   <= 1'b1;
               mem_ir      <= NOP_IR;
               mem_addr    <= sp_in;
               mem_wdata   <= irq_pc;
               mem_alu_res <= irq_pc;
               sf1         <= 1'b1;
               irq_ack     <= 1'b0;
               irq_busy    <= 1'b1;
               state       <= ACK;
            end
            ACK: begin
               // Bubble behind the push; data registers hold.
               mem_valid <= 1'b0;
               mem_ir    <= NOP_IR;
               sf1       <= 1'b0;
               irq_ack   <= 1'b1;
               irq_busy  <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               // IDLE and HOLD share the normal capture path.
               sf1     <= 1'b0;
               irq_ack <= 1'b0;
               if (flush) begin
                  mem_valid <= 1'b0;
                  mem_ir    <= NOP_IR;
               end else begin
                  mem_valid   <= ex_valid;
                  mem_ir      <= ex_valid ? ex_ir : NOP_IR;
                  mem_alu_res <= ex_alu_res;
                  mem_addr    <= ex_mem_addr;
                  mem_wdata   <= ex_wdata;
               end

               if (state == HOLD) begin
                  irq_busy <= 1'b1;
                  // EX is drained once nothing valid survives into MEM.
                  if (!ex_valid || flush) begin
                     state <= PUSH;
                  end
               end else if (irq && armed) begin
                  state    <= HOLD;
                  armed    <= 1'b0;
                  irq_busy <= 1'b1;
               end else begin
                  irq_busy <= 1'b0;
                  if (!irq) begin
                     armed <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
